// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between hashing-engine
// requesters, with locked bursts, bounded burst length and fixed-latency read return.
module sha_mem_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        rdata,
  output logic [NREQ-1:0]      rvalid,
  output logic                 busy,
  output logic                 mem_clk,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_write_data,
  input  logic [DW-1:0]        mem_read_data
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, OWNED} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [CW-1:0]   count, count_nx;
  logic            s1_valid, s1_valid_nx, s2_valid;
  logic [IW-1:0]   s1_id, s1_id_nx, s2_id;
  logic            mem_we_nx;
  logic [AW-1:0]   mem_addr_nx;
  logic [DW-1:0]   mem_write_data_nx;
  logic [NREQ-1:0] rvalid_nx;
  logic            busy_nx;
  logic [NREQ-1:0] gnt_c;
  logic            found;
  logic [IW-1:0]   win;
  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];

  assign mem_clk = clk;
  assign rdata   = mem_read_data;
  assign gnt     = reset_n ? gnt_c : '0;

  // (a + k) mod NREQ for k < NREQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = addr[i*AW +: AW];
      wdata_a[i] = wdata[i*DW +: DW];
    end
  end

  // Grant selection, ownership tracking, issue path and read pipeline next values
  always_comb begin
    state_nx          = state;
    ptr_nx            = ptr;
    owner_nx          = owner;
    count_nx          = count;
    found             = 1'b0;
    win               = '0;
    gnt_c             = '0;
    mem_we_nx         = 1'b0;
    mem_addr_nx       = mem_addr;
    mem_write_data_nx = mem_write_data;
    s1_valid_nx       = 1'b0;
    s1_id_nx          = s1_id;

    if (state == OWNED) begin
      found = req[owner];
      win   = owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[wrap_add(ptr, k)]) begin
          found = 1'b1;
          win   = wrap_add(ptr, k);
        end
      end
    end

    if (found) begin
      gnt_c             = NREQ'(1) << win;
      mem_we_nx         = we[win];
      mem_addr_nx       = addr_a[win];
      mem_write_data_nx = wdata_a[win];
      s1_valid_nx       = ~we[win];
      s1_id_nx          = win;
    end

    case (state)
      ARB: begin
        if (found) begin
          if (lock[win] && (MAX_BURST > 1)) begin
            state_nx = OWNED;
            owner_nx = win;
            count_nx = CW'(1);
          end else begin
            ptr_nx = wrap_add(win, 1);
          end
        end
      end
      OWNED: begin
        if (!found) begin
          state_nx = ARB;
          ptr_nx   = wrap_add(owner, 1);
          count_nx = '0;
        end else begin
          count_nx = count + CW'(1);
          // Last beat, or burst cap reached even though lock is still asserted
          if (!lock[owner] || (count_nx == CW'(MAX_BURST))) begin
            state_nx = ARB;
            ptr_nx   = wrap_add(owner, 1);
            count_nx = '0;
          end
        end
      end
      default: state_nx = ARB;
    endcase

    rvalid_nx = s2_valid ? (NREQ'(1) << s2_id) : '0;
    busy_nx   = (state_nx == OWNED) || s1_valid_nx || s1_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ARB;
      ptr            <= '0;
      owner          <= '0;
      count          <= '0;
      s1_valid       <= 1'b0;
      s1_id          <= '0;
      s2_valid       <= 1'b0;
      s2_id          <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      rvalid         <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      ptr            <= ptr_nx;
      owner          <= owner_nx;
      count          <= count_nx;
      s1_valid       <= s1_valid_nx;
      s1_id          <= s1_id_nx;
      s2_valid       <= s1_valid;
      s2_id          <= s1_id;
      mem_we         <= mem_we_nx;
      mem_addr       <= mem_addr_nx;
      mem_write_data <= mem_write_data_nx;
      rvalid         <= rvalid_nx;
      busy           <= busy_nx;
    end
  end

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Randomized scoreboard bench for sha_mem_arbiter: a grant/ownership reference model
// drives expectations, a separate monitor matches returned reads against a queue.
module tb_sha_mem_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;
  localparam int AW        = 16;
  localparam int DW        = 32;

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req, lock, we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt;
  logic [DW-1:0]        rdata;
  logic [NREQ-1:0]      rvalid;
  logic                 busy;
  logic                 mem_clk;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_write_data;
  logic [DW-1:0]        mem_read_data;

  sha_mem_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 16) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(a) * 32'h0101;
  endfunction

  // Physical memory: two-cycle read latency (sampled address, then output register)
  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] q1;
  logic mem_ready = 1'b0;
  always @(posedge mem_clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 256; a++) mem_arr[a] <= init_word(a);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_write_data;
    end
    q1            <= mem_arr[mem_addr[7:0]];
    mem_read_data <= q1;
  end

  // Reference model state
  typedef struct { int id; logic [DW-1:0] data; int cyc; } exp_t;
  exp_t sbq[$];
  logic [DW-1:0] model_mem [256];
  int m_ptr, m_owner, m_count;
  logic exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  bit rd_now, rd_prev;
  int last_g;
  logic [NREQ-1:0] last_gnt;
  logic [DW-1:0] last_rdata [NREQ];

  function automatic void m_reset();
    m_ptr = 0; m_owner = -1; m_count = 0;
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    rd_now = 1'b0; rd_prev = 1'b0;
  endfunction

  function automatic int pick();
    int i;
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // One clock: predict and check the grant, advance the model, check registered outputs
  task automatic step();
    int g;
    logic [NREQ-1:0] eg;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    g = pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", gnt, eg);
    last_g = g;
    last_gnt = gnt;
    rd_prev = rd_now;
    rd_now = 1'b0;
    exp_we = 1'b0;
    if (g >= 0) begin
      a = addr[g*AW +: AW];
      d = wdata[g*DW +: DW];
      exp_we = we[g];
      exp_addr = a;
      exp_wd = d;
      if (we[g]) model_mem[a[7:0]] = d;
      else begin
        rd_now = 1'b1;
        sbq.push_back('{g, model_mem[a[7:0]], cyc + 3});
      end
    end
    if (m_owner >= 0) begin
      if (g < 0) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_count++;
        if (!lock[g] || m_count == MAX_BURST) begin
          m_ptr = (g + 1) % NREQ;
          m_owner = -1;
          m_count = 0;
        end
      end
    end else if (g >= 0) begin
      if (lock[g] && MAX_BURST > 1) begin
        m_owner = g;
        m_count = 1;
      end else begin
        m_ptr = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
    chk("mem_we", mem_we, exp_we);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_write_data", mem_write_data, exp_wd);
    chk("busy", busy, (m_owner >= 0) || rd_now || rd_prev);
  endtask

  // Read-return monitor, independent of stimulus
  exp_t mon_e;
  logic [NREQ-1:0] mon_oh;
  always @(negedge clk) begin
    if (reset_n) begin
      if (rvalid != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got rvalid=%b expected none (cycle %0d)", rvalid, cyc);
        end else begin
          mon_e = sbq.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.id] = 1'b1;
          chk("rvalid_id", rvalid, mon_oh);
          chk("rdata", rdata, mon_e.data);
          chk("rvalid_cycle", cyc, mon_e.cyc);
          last_rdata[mon_e.id] = rdata;
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        mon_e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL rvalid_missing: got none expected rvalid for %0d at cycle %0d", mon_e.id, mon_e.cyc);
      end
    end
  end

  task automatic set_req(input int i, input bit r, input bit l, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    lock[i] = l;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, '0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_mem_wd"}, mem_write_data, '0);
    chk({tag, "_rvalid"}, rvalid, '0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Short asynchronous reset pulse between clock edges
  task automatic do_reset();
    reset_n = 1'b0;
    sbq.delete();
    m_reset();
    #1;
    check_reset_outputs("async_reset");
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [NREQ-1:0] rr_exp [5];
  int wcnt;

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int a = 0; a < 256; a++) model_mem[a] = init_word(a);
    for (int i = 0; i < NREQ; i++) last_rdata[i] = '0;
    m_reset();
    last_g = -1;
    reset_n = 1'b0;
    req = '1; lock = '0; we = '0; addr = '0; wdata = '0;
    #12;
    check_reset_outputs("reset");
    req = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single read
    set_req(1, 1, 0, 0, 16'h0010, '0);
    step();
    chk("single_gnt", last_gnt, 4'b0010);
    req = '0;
    repeat (4) step();
    chk("single_rdata", last_rdata[1], 32'hDEADBEEF);

    // Round robin from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 16'(8 + i), '0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_order", last_gnt, rr_exp[k]);
    end
    req = '0;
    repeat (4) step();

    // Locked 16-beat burst with a competing requester
    set_req(0, 1, 0, 0, 16'h0020, '0);
    for (int k = 0; k < 16; k++) begin
      set_req(2, 1, (k < 15), 0, 16'(k), '0);
      step();
      chk("burst_gnt", last_gnt, 4'b0100);
    end
    req[2] = 1'b0;
    step();
    chk("burst_release", last_gnt, 4'b0001);
    req = '0;
    repeat (4) step();

    // Forced release at MAX_BURST
    set_req(3, 1, 1, 0, 16'h0030, '0);
    step();
    chk("forced_gnt", last_gnt, 4'b1000);
    set_req(1, 1, 0, 0, 16'h0031, '0);
    for (int k = 1; k < MAX_BURST; k++) begin
      step();
      chk("forced_gnt", last_gnt, 4'b1000);
    end
    step();
    chk("forced_next", last_gnt, 4'b0010);
    req[1] = 1'b0;
    step();
    chk("forced_resume", last_gnt, 4'b1000);
    repeat (2) step();
    req = '0;
    repeat (4) step();

    // Write then read the same word
    wcnt = 0;
    set_req(0, 1, 0, 1, 16'h0040, 32'hCAFEF00D);
    step();
    if (mem_we) wcnt++;
    chk("wr_gnt", last_gnt, 4'b0001);
    we[0] = 1'b0;
    step();
    if (mem_we) wcnt++;
    req = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (mem_we) wcnt++;
    end
    chk("wr_once", wcnt, 1);
    chk("wr_rd_data", last_rdata[0], 32'hCAFEF00D);

    // Reset while a read is in flight
    set_req(1, 1, 0, 0, 16'h0010, '0);
    step();
    req = '0;
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 16'(4 * i), '0);
    do_reset();
    step();
    chk("post_reset_gnt", last_gnt, 4'b0001);
    req = '0;
    repeat (5) step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && last_g != i) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, 1, lock[i], ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 255)), $urandom);
        end else begin
          set_req(i, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 255)), $urandom);
        end
      end
    end
    req = '0;
    repeat (6) step();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
